// File: rtl/arm_mac_seq_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : arm_mac_seq_pkg
// Purpose : Shared types and constants for the sequential ARM MUL/MLA unit:
//           FSM state encoding, datapath width, iteration count, flag bit
//           positions and a helper that forms the {N,Z,C,V} nibble.
// Ports   : (package - none)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package arm_mac_seq_pkg;

   localparam int MAC_WIDTH = 32;
   localparam int MAC_ITERS = 32;

   // Bit positions inside mac_cpsr
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Iteration counter value at which the last MUL step executes
   localparam logic [4:0] CNT_LAST = 5'(MAC_ITERS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } mac_state_t;

   // C and V are masked by the core, so only N and Z carry information.
   function automatic logic [3:0] mac_flags(input logic [MAC_WIDTH-1:0] res);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = res[MAC_WIDTH-1];
      f[FLAG_Z] = (res == '0);
      f[FLAG_C] = 1'b0;
      f[FLAG_V] = 1'b0;
      return f;
   endfunction

endpackage : arm_mac_seq_pkg
`default_nettype wire

// File: rtl/arm_mac_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : arm_mac_seq
// Purpose : Iterative shift-and-add multiplier for ARM MUL / MLA. One
//           multiplier bit is consumed per cycle; an optional accumulate
//           cycle adds Rn. A single adder is shared by both phases.
// Ports   : clk      - clock, rising edge
//           rst_b    - synchronous active-low reset
//           start    - begin a multiply (sampled in IDLE only)
//           flush    - abort any operation, return to IDLE
//           mac_op1  - multiplicand (Rm)
//           mac_op2  - multiplier (Rs)
//           mac_acc  - accumulator (Rn)
//           mac_sel  - 1 = MLA, 0 = MUL
//           busy     - state is not IDLE (registered)
//           done     - one-cycle result-valid pulse (registered)
//           mac_out  - low 32 bits of result (registered, held)
//           mac_cpsr - {N,Z,C,V} of result (registered, held)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module arm_mac_seq
   import arm_mac_seq_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 start,
   input  logic                 flush,
   input  logic [MAC_WIDTH-1:0] mac_op1,
   input  logic [MAC_WIDTH-1:0] mac_op2,
   input  logic [MAC_WIDTH-1:0] mac_acc,
   input  logic                 mac_sel,
   output logic                 busy,
   output logic                 done,
   output logic [MAC_WIDTH-1:0] mac_out,
   output logic [3:0]           mac_cpsr
);

   mac_state_t           r_state;
   logic [MAC_WIDTH-1:0] r_mcand;
   logic [MAC_WIDTH-1:0] r_mplier;
   logic [MAC_WIDTH-1:0] r_acc;
   logic                 r_sel;
   logic [MAC_WIDTH-1:0] r_prod;
   logic [4:0]           r_count;
   logic                 r_busy;
   logic                 r_done;
   logic [MAC_WIDTH-1:0] r_out;
   logic [3:0]           r_cpsr;

   logic [MAC_WIDTH-1:0] w_addend;
   logic [MAC_WIDTH-1:0] w_sum;
   logic [MAC_WIDTH-1:0] w_mplier_next;
   logic                 w_mul_last;

   // The one adder: product plus either the gated multiplicand (MUL) or
   // the captured accumulator (ACC).
   always_comb begin
      w_addend = '0;
      if (r_state == ACC) begin
         w_addend = r_acc;
      end else if (r_mplier[0]) begin
         w_addend = r_mcand;
      end
   end

   assign w_sum         = r_prod + w_addend;
   assign w_mplier_next = r_mplier >> 1;

   // Early exit is tested on the already-shifted multiplier, so at least
   // one iteration always runs.
   assign w_mul_last = (r_count == CNT_LAST) ||
                       (EARLY_TERM && (w_mplier_next == '0));

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state  <= IDLE;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_sel    <= 1'b0;
         r_prod   <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_out    <= '0;
         r_cpsr   <= '0;
      end else if (flush) begin
         // Abort wins over everything but reset; results are left untouched.
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_mcand  <= mac_op1;
                  r_mplier <= mac_op2;
                  r_acc    <= mac_acc;
                  r_sel    <= mac_sel;
                  r_prod   <= '0;
                  r_count  <= '0;
                  r_state  <= MUL;
                  r_busy   <= 1'b1;
               end
            end
            MUL: begin
               r_prod   <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= w_mplier_next;
               r_count  <= r_count + 5'd1;
               if (w_mul_last) begin
                  if (r_sel) begin
                     r_state <= ACC;
                  end else begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_out   <= w_sum;
                     r_cpsr  <= mac_flags(w_sum);
                  end
               end
            end
            ACC: begin
               r_prod  <= w_sum;
               r_state <= DONE;
               r_done  <= 1'b1;
               r_out   <= w_sum;
               r_cpsr  <= mac_flags(w_sum);
            end
            DONE: begin
               // Any start seen here is dropped, not queued.
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign mac_out  = r_out;
   assign mac_cpsr = r_cpsr;

endmodule : arm_mac_seq
`default_nettype wire

// File: tb/tb_arm_mac_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_arm_mac_seq
// Purpose : Directed self-checking bench for arm_mac_seq. Two instances share
//           stimulus: one with EARLY_TERM=0, one with EARLY_TERM=1 (its start
//           can be masked). Cycle numbering: cycle 1 is the cycle right after
//           the start-sample edge, so done sampled high at edge k is cycle k.
// Ports   : (none)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_arm_mac_seq;

   logic        clk;
   logic        rst_b;
   logic        start;
   logic        flush;
   logic [31:0] mac_op1;
   logic [31:0] mac_op2;
   logic [31:0] mac_acc;
   logic        mac_sel;
   logic        en1;
   logic        w_start1;

   logic        busy0, done0, busy1, done1;
   logic [31:0] out0, out1;
   logic [3:0]  cpsr0, cpsr1;

   int n_cmp;
   int n_bad;

   assign w_start1 = start & en1;

   arm_mac_seq #(.EARLY_TERM(1'b0)) u_dut0 (
      .clk(clk), .rst_b(rst_b), .start(start), .flush(flush),
      .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_acc(mac_acc), .mac_sel(mac_sel),
      .busy(busy0), .done(done0), .mac_out(out0), .mac_cpsr(cpsr0)
   );

   arm_mac_seq #(.EARLY_TERM(1'b1)) u_dut1 (
      .clk(clk), .rst_b(rst_b), .start(w_start1), .flush(flush),
      .mac_op1(mac_op1), .mac_op2(mac_op2), .mac_acc(mac_acc), .mac_sel(mac_sel),
      .busy(busy1), .done(done1), .mac_out(out1), .mac_cpsr(cpsr1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Launch one operation and watch both instances for 60 cycles, recording
   // the cycle of the first done, the result at that point, and pulse count.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic sel, input logic use1,
                         output int cyc0, output int cyc1,
                         output logic [31:0] r0, output logic [31:0] r1,
                         output logic [3:0] f0, output logic [3:0] f1,
                         output int nd0, output int nd1);
      cyc0 = 0; cyc1 = 0; r0 = 'x; r1 = 'x; f0 = 'x; f1 = 'x; nd0 = 0; nd1 = 0;
      @(negedge clk);
      mac_op1 = a; mac_op2 = b; mac_acc = c; mac_sel = sel; en1 = use1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      mac_op1 = 32'hDEAD_BEEF; mac_op2 = 32'hFFFF_FFFF; mac_acc = 32'h5555_5555; mac_sel = ~sel;
      for (int i = 1; i <= 60; i++) begin
         if (done0) begin
            if (nd0 == 0) begin cyc0 = i; r0 = out0; f0 = cpsr0; end
            nd0++;
         end
         if (done1) begin
            if (nd1 == 0) begin cyc1 = i; r1 = out1; f1 = cpsr1; end
            nd1++;
         end
         @(posedge clk);
         #1;
      end
      en1 = 1'b0;
   endtask

   int          c0, c1, d0, d1, nd;
   logic [31:0] o0, o1;
   logic [3:0]  p0, p1;
   logic        seen_busy_after;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_b = 1'b0; start = 1'b0; flush = 1'b0; en1 = 1'b0;
      mac_op1 = '0; mac_op2 = '0; mac_acc = '0; mac_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy0}, 32'd0);
      chk("reset_done", {31'd0, done0}, 32'd0);
      chk("reset_out",  out0, 32'd0);
      chk("reset_cpsr", {28'd0, cpsr0}, 32'd0);
      rst_b = 1'b1;

      // MUL 7*6
      run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("mul7x6_cycle",  c0, 33);
      chk("mul7x6_out",    o0, 32'h0000_002A);
      chk("mul7x6_cpsr",   {28'd0, p0}, 32'd0);
      chk("mul7x6_npulse", d0, 1);
      chk("mul7x6_et_cycle", c1, 4);
      chk("mul7x6_et_out",   o1, 32'h0000_002A);

      // MLA 0xFFFFFFFF*2 + 5
      run_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("mla_cycle",   c0, 34);
      chk("mla_out",     o0, 32'h0000_0003);
      chk("mla_cpsr",    {28'd0, p0}, 32'd0);
      chk("mla_et_cycle", c1, 4);
      chk("mla_et_out",   o1, 32'h0000_0003);

      // MUL 0x80000000*1 : negative result
      run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("neg_out",      o0, 32'h8000_0000);
      chk("neg_cpsr",     {28'd0, p0}, 32'h8);
      chk("neg_et_cycle", c1, 2);

      // MUL 0x1234*0 : zero result, early exit after one step
      run_op(32'h1234, 32'd0, 32'd0, 1'b0, 1'b1, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("zero_et_cycle", c1, 2);
      chk("zero_et_out",   o1, 32'd0);
      chk("zero_et_cpsr",  {28'd0, p1}, 32'h4);
      chk("zero_cycle",    c0, 33);
      chk("zero_cpsr",     {28'd0, p0}, 32'h4);

      // 3*3 with a second start (5*5) in cycle 10: ignored, single done
      @(negedge clk);
      mac_op1 = 32'd3; mac_op2 = 32'd3; mac_acc = '0; mac_sel = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nd = 0; c0 = 0; o0 = 'x; seen_busy_after = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 10) begin mac_op1 = 32'd5; mac_op2 = 32'd5; start = 1'b1; end
         if (i == 11) start = 1'b0;
         if (done0) begin
            if (nd == 0) begin c0 = i; o0 = out0; end
            nd++;
         end
         if (c0 != 0 && i > c0 && busy0) seen_busy_after = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("busy_start_ndone", nd, 1);
      chk("busy_start_out",   o0, 32'd9);
      chk("busy_start_cycle", c0, 33);
      chk("busy_after_done",  {31'd0, seen_busy_after}, 32'd0);

      // Flush in cycle 10 of 9*9
      @(negedge clk);
      mac_op1 = 32'd9; mac_op2 = 32'd9; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nd = 0;
      for (int i = 1; i <= 50; i++) begin
         if (i == 10) flush = 1'b1;
         if (i == 11) begin
            flush = 1'b0;
            chk("flush_busy", {31'd0, busy0}, 32'd0);
         end
         if (done0) nd++;
         @(posedge clk);
         #1;
      end
      chk("flush_ndone", nd, 0);
      chk("flush_out_kept", out0, 32'd9);

      // flush together with start in IDLE: start dropped
      @(negedge clk);
      mac_op1 = 32'd2; mac_op2 = 32'd2; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", {31'd0, busy0}, 32'd0);

      run_op(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("after_flush_out", o0, 32'd4);

      // Reset in cycle 15 of an MLA
      @(negedge clk);
      mac_op1 = 32'd7; mac_op2 = 32'd9; mac_acc = 32'd100; mac_sel = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      nd = 0;
      for (int i = 1; i <= 50; i++) begin
         if (i == 15) rst_b = 1'b0;
         if (i == 16) begin
            rst_b = 1'b1;
            chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
            chk("rst_mid_out",  out0, 32'd0);
            chk("rst_mid_cpsr", {28'd0, cpsr0}, 32'd0);
         end
         if (done0) nd++;
         @(posedge clk);
         #1;
      end
      chk("rst_mid_ndone", nd, 0);

      run_op(32'd3, 32'd4, 32'd0, 1'b0, 1'b0, c0, c1, o0, o1, p0, p1, d0, d1);
      chk("after_rst_out",   o0, 32'h0000_000C);
      chk("after_rst_cycle", c0, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_arm_mac_seq
`default_nettype wire
